// File: rtl/multicycle_control_if.sv
// Memory request handshake between the multicycle sequencer (master) and the memory port (slave).
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// Main sequencer of the multicycle datapath: FETCH/DECODE/EXEC/MEM/WB with a memory stall watchdog.
// Optional macro ILLEGAL_TRAP_EN: opcodes above HALT trap into HALT and set illegal_op; otherwise they act as NOP.
module multicycle_control #(
    parameter int OPCODE_WIDTH = 4,
    parameter int MAX_WAIT     = 15
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    run,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero_flag,
    multicycle_control_if.master    mem,
    output logic                    ir_write,
    output logic                    counter_write,
    output logic                    counter_increment,
    output logic                    reg_write,
    output logic                    wb_sel,
    output logic [1:0]              alu_op,
    output logic                    halted,
    output logic                    bus_error,
    output logic                    illegal_op,
    output logic [3:0]              state_dbg
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND   = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQZ  = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(8);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC   = 4'd3,
        MEM_RD = 4'd4,
        MEM_WR = 4'd5,
        WB     = 4'd6,
        BRANCH = 4'd7,
        HALT   = 4'd8
    } state_t;

    state_t              state_reg, state_next;
    state_t              next_instr;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic                from_load_reg, from_load_next;
    logic                bus_error_reg, bus_error_next;
    logic                mem_req, mem_we, addr_sel;
    logic [1:0]          alu_dec;

    // run only matters at instruction boundaries, which all route through next_instr
    assign next_instr = run ? FETCH : IDLE;

    always_comb begin
        case (opcode)
            OP_ADD:  alu_dec = 2'b00;
            OP_SUB:  alu_dec = 2'b01;
            OP_AND:  alu_dec = 2'b10;
            default: alu_dec = 2'b11;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_reg, illegal_next;
    assign illegal_op = illegal_reg;
`else
    assign illegal_op = 1'b0;
`endif

    always_comb begin
        state_next        = state_reg;
        wait_cnt_next     = '0;
        from_load_next    = from_load_reg;
        bus_error_next    = bus_error_reg;
`ifdef ILLEGAL_TRAP_EN
        illegal_next      = illegal_reg;
`endif
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        addr_sel          = 1'b0;
        ir_write          = 1'b0;
        counter_write     = 1'b0;
        counter_increment = 1'b0;
        reg_write         = 1'b0;
        wb_sel            = 1'b0;
        alu_op            = 2'b00;
        halted            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_write          = 1'b1;
                    counter_increment = 1'b1;
                    state_next        = DECODE;
                end
            end
            DECODE: begin
                from_load_next = (opcode == OP_LOAD);
                case (opcode)
                    OP_NOP:                 state_next = next_instr;
                    OP_ADD, OP_SUB, OP_AND: state_next = EXEC;
                    OP_LOAD:                state_next = MEM_RD;
                    OP_STORE:               state_next = MEM_WR;
                    OP_JMP, OP_BEQZ:        state_next = BRANCH;
                    OP_HALT:                state_next = HALT;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_next   = HALT;
                        illegal_next = 1'b1;
`else
                        state_next   = next_instr;
`endif
                    end
                endcase
            end
            EXEC: begin
                alu_op     = alu_dec;
                state_next = WB;
            end
            WB: begin
                reg_write  = 1'b1;
                wb_sel     = from_load_reg;
                alu_op     = alu_dec;
                state_next = next_instr;
            end
            MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (mem.mem_ready) state_next = WB;
            end
            MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                if (mem.mem_ready) state_next = next_instr;
            end
            BRANCH: begin
                counter_write = (opcode == OP_JMP) || ((opcode == OP_BEQZ) && zero_flag);
                state_next    = next_instr;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        // Stall watchdog shared by all request states; a same-cycle mem_ready never counts as a stall
        if (mem_req && !mem.mem_ready) begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
            if (wait_cnt_reg == WAIT_W'(MAX_WAIT - 1)) begin
                state_next     = HALT;
                bus_error_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            from_load_reg <= 1'b0;
            bus_error_reg <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            from_load_reg <= from_load_next;
            bus_error_reg <= bus_error_next;
`ifdef ILLEGAL_TRAP_EN
            illegal_reg   <= illegal_next;
`endif
        end
    end

    assign mem.mem_req  = mem_req;
    assign mem.mem_we   = mem_we;
    assign mem.addr_sel = addr_sel;
    assign bus_error    = bus_error_reg;
    assign state_dbg    = state_reg;
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle output trace from the
// instruction timing rules, then played against the DUT with randomized stalls, run and don't-care inputs.
module tb_multicycle_control;
    localparam int OW       = 4;
    localparam int MAX_WAIT = 15;

    // Observed vector: {req, we, addr_sel, ir_write, cw, ci, reg_write, wb_sel, alu_op[1:0], halted, bus_error, illegal_op}
    localparam logic [12:0] M_REQ  = 13'h1000;
    localparam logic [12:0] M_WE   = 13'h0800;
    localparam logic [12:0] M_AS   = 13'h0400;
    localparam logic [12:0] M_IR   = 13'h0200;
    localparam logic [12:0] M_CW   = 13'h0100;
    localparam logic [12:0] M_CI   = 13'h0080;
    localparam logic [12:0] M_RW   = 13'h0040;
    localparam logic [12:0] M_WB   = 13'h0020;
    localparam logic [12:0] M_ALU  = 13'h0018;
    localparam logic [12:0] M_HALT = 13'h0004;
    localparam logic [12:0] M_BERR = 13'h0002;
    localparam logic [12:0] M_ILL  = 13'h0001;
    localparam logic [12:0] CARE_ALL  = 13'h1FFF;
    localparam logic [12:0] CARE_CTL  = CARE_ALL & ~(M_ALU | M_WB);
    localparam logic [12:0] CARE_NOWE = CARE_CTL & ~M_WE;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic        rdy;
        logic        run;
        logic [3:0]  op;
        logic        zf;
        logic [12:0] val;
        logic [12:0] care;
        logic        idle;
    } cyc_t;

    logic          clock;
    logic          resetn;
    logic          run;
    logic [OW-1:0] opcode;
    logic          zero_flag;
    logic          ir_write, counter_write, counter_increment, reg_write, wb_sel;
    logic [1:0]    alu_op;
    logic          halted, bus_error, illegal_op;
    logic [3:0]    state_dbg;

    multicycle_control_if bus ();

    multicycle_control #(.OPCODE_WIDTH(OW), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .resetn(resetn), .run(run), .opcode(opcode), .zero_flag(zero_flag),
        .mem(bus.master),
        .ir_write(ir_write), .counter_write(counter_write), .counter_increment(counter_increment),
        .reg_write(reg_write), .wb_sel(wb_sel), .alu_op(alu_op), .halted(halted),
        .bus_error(bus_error), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   checks   = 0;
    int   failures = 0;
    int   cyc_no   = 0;
    cyc_t q[$];
    string tag_q[$];

    function automatic logic [12:0] observed();
        return {bus.mem_req, bus.mem_we, bus.addr_sel, ir_write, counter_write, counter_increment,
                reg_write, wb_sel, alu_op, halted, bus_error, illegal_op};
    endfunction

    function automatic logic [12:0] alu_bits(input int op);
        case (op)
            1:       return 13'h0000;   // ADD 00
            2:       return 13'h0008;   // SUB 01
            3:       return 13'h0010;   // AND 10
            default: return 13'h0018;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rdy, input logic r, input int op, input logic zf,
                        input logic [12:0] val, input logic [12:0] care, input logic idle, input string tag);
        cyc_t e;
        e.rdy = rdy; e.run = r; e.op = 4'(op); e.zf = zf;
        e.val = val; e.care = care; e.idle = idle;
        q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic idle_go();
        push(rb(), 1'b1, 0, 1'b0, 13'h0, CARE_ALL, 1'b1, "idle_go");
    endtask

    // One instruction: fs fetch stalls, ms memory stalls, last_run = run value on its final cycle
    task automatic instr(input int op, input logic zf, input int fs, input int ms, input logic last_run);
        bit halts;
        halts = (op == 8) || (op >= 9 && TRAP);
        for (int i = 0; i < fs; i++) push(1'b0, rb(), op, zf, M_REQ, CARE_CTL, 1'b0, "fetch_wait");
        push(1'b1, rb(), op, zf, M_REQ | M_IR | M_CI, CARE_CTL, 1'b0, "fetch");
        if (op == 0 || (op >= 9 && !TRAP)) begin
            push(rb(), last_run, op, zf, 13'h0, CARE_NOWE, 1'b0, "decode_nop");
        end else begin
            push(rb(), rb(), op, zf, 13'h0, CARE_NOWE, 1'b0, "decode");
            if (op >= 1 && op <= 3) begin
                push(rb(), rb(), op, zf, alu_bits(op), CARE_NOWE | M_ALU, 1'b0, "exec");
                push(rb(), last_run, op, zf, M_RW | alu_bits(op), CARE_NOWE | M_ALU | M_WB, 1'b0, "wb_alu");
            end else if (op == 4) begin
                for (int i = 0; i < ms; i++) push(1'b0, rb(), op, zf, M_REQ | M_AS, CARE_CTL, 1'b0, "mem_rd_wait");
                push(1'b1, rb(), op, zf, M_REQ | M_AS, CARE_CTL, 1'b0, "mem_rd");
                push(rb(), last_run, op, zf, M_RW | M_WB, CARE_NOWE | M_WB, 1'b0, "wb_load");
            end else if (op == 5) begin
                for (int i = 0; i < ms; i++) push(1'b0, rb(), op, zf, M_REQ | M_WE | M_AS, CARE_CTL, 1'b0, "mem_wr_wait");
                push(1'b1, last_run, op, zf, M_REQ | M_WE | M_AS, CARE_CTL, 1'b0, "mem_wr");
            end else if (op == 6 || op == 7) begin
                push(rb(), last_run, op, zf, (op == 6 || zf) ? M_CW : 13'h0, CARE_NOWE, 1'b0, "branch");
            end else begin
                for (int i = 0; i < 3; i++)
                    push(rb(), rb(), op, zf, M_HALT | ((op >= 9) ? M_ILL : 13'h0), CARE_NOWE, 1'b0, "halt");
            end
        end
        if (!halts && !last_run) begin
            push(rb(), 1'b0, op, zf, 13'h0, CARE_ALL, 1'b1, "idle_wait");
            idle_go();
        end
    endtask

    task automatic play();
        cyc_t        e;
        string       t;
        logic [12:0] obs;
        while (q.size() > 0) begin
            e = q.pop_front();
            t = tag_q.pop_front();
            @(negedge clock);
            opcode = e.op; zero_flag = e.zf; run = e.run; bus.mem_ready = e.rdy;
            #1;
            cyc_no++;
            obs = observed();
            checks++;
            assert ((obs & e.care) === (e.val & e.care)) else begin
                failures++;
                $error("FAIL %s cyc=%0d op=%0d observed=%h expected=%h care=%h", t, cyc_no, e.op, obs, e.val, e.care);
            end
            checks++;
            assert (!(counter_write && counter_increment)) else begin
                failures++;
                $error("FAIL cw_ci_overlap cyc=%0d observed cw=%b ci=%b expected not both", cyc_no, counter_write, counter_increment);
            end
            if (e.idle) begin
                checks++;
                assert (state_dbg === 4'd0) else begin
                    failures++;
                    $error("FAIL idle_state cyc=%0d observed=%0d expected=0", cyc_no, state_dbg);
                end
            end
            $display("cyc=%0d %s op=%0d rdy=%b run=%b outs=%h", cyc_no, t, e.op, e.rdy, e.run, obs);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0; run = 1'b0; bus.mem_ready = 1'b0;
        #1;
        checks++;
        assert ({observed(), state_dbg} === 17'h0) else begin
            failures++;
            $error("FAIL reset_outputs observed=%h state=%0d expected all 0", observed(), state_dbg);
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; run = 1'b0; opcode = '0; zero_flag = 1'b0; bus.mem_ready = 1'b0;
        do_reset();

        // ALU zero-wait, LOAD with 3-cycle stall, BEQZ both ways, JMP, STORE, NOP
        idle_go();
        instr(1, 1'b0, 0, 0, 1'b1);
        instr(4, 1'b0, 0, 3, 1'b1);
        instr(7, 1'b0, 0, 0, 1'b1);
        instr(7, 1'b1, 0, 0, 1'b1);
        instr(6, 1'b0, 0, 0, 1'b1);
        instr(5, 1'b0, 2, 1, 1'b1);
        instr(0, 1'b1, 0, 0, 1'b0);
        // Stall boundary: mem_ready on the MAX_WAIT-th stall cycle completes normally
        instr(2, 1'b0, MAX_WAIT - 1, 0, 1'b1);
        instr(4, 1'b0, 0, MAX_WAIT - 1, 1'b1);
        instr(5, 1'b0, 0, MAX_WAIT - 1, 1'b1);
        play();

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            instr($urandom_range(0, 7), rb(),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                  ($urandom_range(0, 4) != 0));
        end
        play();

        // Illegal opcode 12
        instr(12, 1'b0, 0, 0, 1'b1);
        if (!TRAP) instr(3, 1'b0, 0, 0, 1'b1);
        play();

        // HALT opcode, left only via reset
        do_reset();
        idle_go();
        instr(8, 1'b0, 1, 0, 1'b1);
        play();

        // Reset in the middle of a stalled MEM_WR
        do_reset();
        idle_go();
        push(1'b1, 1'b1, 5, 1'b0, M_REQ | M_IR | M_CI, CARE_CTL, 1'b0, "fetch");
        push(1'b0, 1'b1, 5, 1'b0, 13'h0, CARE_NOWE, 1'b0, "decode");
        push(1'b0, 1'b1, 5, 1'b0, M_REQ | M_WE | M_AS, CARE_CTL, 1'b0, "mem_wr_wait");
        play();
        @(posedge clock);
        #2;
        checks++;
        assert (bus.mem_req === 1'b1) else begin
            failures++;
            $error("FAIL pre_reset_req observed=%b expected=1", bus.mem_req);
        end
        resetn = 1'b0;
        run = 1'b0;
        #1;
        checks++;
        assert ({bus.mem_req, state_dbg} === 5'h0) else begin
            failures++;
            $error("FAIL async_reset_req observed req=%b state=%0d expected req=0 state=0", bus.mem_req, state_dbg);
        end
        @(negedge clock);
        resetn = 1'b1;
        push(1'b1, 1'b0, 0, 1'b0, 13'h0, CARE_ALL, 1'b1, "idle_wait");
        push(1'b0, 1'b0, 0, 1'b0, 13'h0, CARE_ALL, 1'b1, "idle_wait");
        idle_go();
        instr(3, 1'b0, 0, 0, 1'b1);
        play();

        // Fetch timeout: MAX_WAIT stalls lead to HALT with sticky bus_error
        for (int i = 0; i < MAX_WAIT; i++) push(1'b0, rb(), 1, 1'b0, M_REQ, CARE_CTL, 1'b0, "fetch_wait");
        for (int i = 0; i < 4; i++) push(rb(), rb(), 1, 1'b0, M_HALT | M_BERR, CARE_NOWE, 1'b0, "halt_berr");
        play();
        do_reset();
        push(1'b1, 1'b0, 0, 1'b0, 13'h0, CARE_ALL, 1'b1, "idle_after_berr");
        play();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
